dma_bus_master: RTL

Synthesizable MC68030-style bus-master cycle generator for the RESDMAC DMA path. It arbitrates for the CPU bus (BR/_BG/_BGACK) and runs LEN consecutive 32-bit read or write cycles, terminated by _DSACK or _STERM. It then releases the bus. It is the initiator counterpart of the RESDMAC register-slave logic and drives the bus only while OWN is high.

---
 rtl/dma_bus_master.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_bus_master.sv
// -----------------------------------------------------------------------------
// dma_bus_master
//
// MC68030-style bus-master cycle generator for the RESDMAC DMA path. It
// requests the CPU bus (BR/_BG/_BGACK), runs LEN consecutive 32-bit read or
// write cycles terminated by _DSACK (or _STERM), then releases the bus.
// Bus strobes are driven active only while OWN is high.
//
// Optional feature macro:
//   STERM_EN  - when defined, _STERM=0 terminates a 32-bit cycle. If it is
//               sampled at the end of S2, WAIT is skipped (3-clock word).
//               When undefined, _STERM is ignored.
//
// Parameters:
//   MAX_WAIT      clocks allowed in WAIT before a timeout abort
//
// Ports:
//   sclk_i        CPU clock, all logic on the rising edge
//   rst_n_i       asynchronous active-low reset
//   start_i       begin a bus tenure (sampled in IDLE only)
//   dir_i         1 = write to memory, 0 = read from memory
//   len_i         word count for the tenure, 0 means 16
//   wdata_i       write word; the next word follows the cycle after word_ack_o
//   rdata_o       read word, valid while word_ack_o is high
//   word_ack_o    one-clock pulse per terminated word
//   done_o        one-clock pulse at normal release
//   err_o         one-clock pulse at abort (bus error, size error, timeout)
//   br_o          bus request
//   bg_n_i        bus grant
//   bgack_n_i     bus grant acknowledge from other masters
//   bgack_n_o     bus grant acknowledge driven by this block
//   as_n_i        address strobe of the current bus master
//   as_n_o        address strobe
//   ds_n_o        data strobe
//   r_w_o         read/write direction (0 = write)
//   dsack_n_i     data-size acknowledge
//   sterm_n_i     synchronous termination
//   berr_n_i      bus error
//   data_i        CPU data bus in
//   data_o        CPU data bus out
//   dmaen_n_o     low enables the address generator
//   own_o         high while this block is bus master
//   data_oe_n_o   low enables the data level shifters (writes only)
// -----------------------------------------------------------------------------
module dma_bus_master #(
   parameter int MAX_WAIT = 15
) (
   input  logic        sclk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        dir_i,
   input  logic [3:0]  len_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        word_ack_o,
   output logic        done_o,
   output logic        err_o,
   output logic        br_o,
   input  logic        bg_n_i,
   input  logic        bgack_n_i,
   output logic        bgack_n_o,
   input  logic        as_n_i,
   output logic        as_n_o,
   output logic        ds_n_o,
   output logic        r_w_o,
   input  logic [1:0]  dsack_n_i,
   input  logic        sterm_n_i,
   input  logic        berr_n_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        dmaen_n_o,
   output logic        own_o,
   output logic        data_oe_n_o
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_GRANT, ST_S1, ST_S2, ST_WAIT, ST_TERM, ST_REL
   } state_e;

   state_e         state_q, state_d;
   logic           dir_q, dir_d;
   logic [4:0]     cnt_q, cnt_d;        // words left in the tenure (1..16)
   logic [WCW-1:0] wait_q, wait_d;      // unterminated WAIT clocks so far
   logic           abort_q, abort_d;    // high in REL when the tenure aborted
   logic [31:0]    rdata_q, rdata_d;
   logic [31:0]    wdata_q, wdata_d;    // write word held after S1

   logic sterm_hit;
   logic term_ok;
   logic size_err;

`ifdef STERM_EN
   assign sterm_hit = ~sterm_n_i;
`else
   // _STERM is ignored in this build; the AND keeps the input read.
   assign sterm_hit = ~sterm_n_i & 1'b0;
`endif

   // Only a full 32-bit port acknowledge is a valid termination; a 16- or
   // 8-bit port answer cannot be handled by this master.
   assign term_ok  = (dsack_n_i == 2'b00) | sterm_hit;
   assign size_err = (dsack_n_i == 2'b01) | (dsack_n_i == 2'b10);

   // State register
   always_ff @(posedge sclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b0;
         cnt_q   <= 5'd0;
         wait_q  <= '0;
         abort_q <= 1'b0;
         rdata_q <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         abort_q <= abort_d;
         rdata_q <= rdata_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      abort_d = 1'b0;
      rdata_d = rdata_q;
      wdata_d = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               dir_d   = dir_i;
               cnt_d   = (len_i == 4'd0) ? 5'd16 : {1'b0, len_i};
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Bus is free only when granted and no other master holds it.
            if (!bg_n_i && as_n_i && bgack_n_i) state_d = ST_GRANT;
         end
         ST_GRANT: begin
            state_d = ST_S1;
         end
         ST_S1: begin
            wdata_d = wdata_i;
            if (!berr_n_i) begin
               abort_d = 1'b1;
               state_d = ST_REL;
            end else begin
               state_d = ST_S2;
            end
         end
         ST_S2: begin
            wait_d = '0;
            if (!berr_n_i) begin
               abort_d = 1'b1;
               state_d = ST_REL;
            end else if (sterm_hit) begin
               rdata_d = data_i;
               state_d = ST_TERM;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Priority: bus error, valid termination, size error, timeout.
            if (!berr_n_i) begin
               abort_d = 1'b1;
               state_d = ST_REL;
            end else if (term_ok) begin
               rdata_d = data_i;
               state_d = ST_TERM;
            end else if (size_err || (wait_q == WCW'(MAX_WAIT - 1))) begin
               abort_d = 1'b1;
               state_d = ST_REL;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_TERM: begin
            cnt_d   = cnt_q - 5'd1;
            state_d = (cnt_q == 5'd1) ? ST_REL : ST_S1;
         end
         ST_REL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode; all bus outputs follow the state register directly so an
   // asynchronous reset returns them to their idle levels at once.
   always_comb begin
      br_o        = 1'b0;
      bgack_n_o   = 1'b1;
      as_n_o      = 1'b1;
      ds_n_o      = 1'b1;
      r_w_o       = 1'b1;
      dmaen_n_o   = 1'b1;
      data_oe_n_o = 1'b1;
      own_o       = 1'b0;
      data_o      = 32'd0;
      word_ack_o  = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      rdata_o     = rdata_q;

      unique case (state_q)
         ST_REQ: begin
            br_o = 1'b1;
         end
         ST_GRANT: begin
            bgack_n_o = 1'b0;
            own_o     = 1'b1;
         end
         ST_S1, ST_S2, ST_WAIT, ST_TERM: begin
            bgack_n_o   = 1'b0;
            own_o       = 1'b1;
            r_w_o       = ~dir_q;
            dmaen_n_o   = 1'b0;
            data_oe_n_o = ~dir_q;
            if (state_q == ST_S1) begin
               as_n_o = 1'b0;
               data_o = dir_q ? wdata_i : 32'd0;
            end else if (state_q == ST_TERM) begin
               word_ack_o = 1'b1;
               data_o     = dir_q ? wdata_q : 32'd0;
            end else begin
               as_n_o = 1'b0;
               ds_n_o = 1'b0;
               data_o = dir_q ? wdata_q : 32'd0;
            end
         end
         ST_REL: begin
            done_o = ~abort_q;
            err_o  = abort_q;
         end
         default: begin
            br_o = 1'b0;
         end
      endcase
   end

endmodule
